dport_responder: RTL and testbench

Data-port responder for the pipeline's MEM stage: accepts the word-level requests produced by MEM-stage control (mem_read, mem_write, 4-bit byte enable) and completes them against a line-granular burst physical memory. Reads fetch the containing line and return the addressed word. Writes perform a read-merge-writeback of the full line. Sits between the datapath's MEM stage and the data-side physical-memory port.

---
 rtl/dport_responder_pkg.sv | 21 ++
 rtl/dport_responder_if.sv | 29 ++
 rtl/dport_responder_line_merge.sv | 29 ++
 rtl/dport_responder.sv | 185 ++++++++++++++++++
 tb/tb_dport_responder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dport_responder_pkg.sv
// dport_types: shared types and constants for the data-port responder.
//   dport_state_t : responder FSM states
//   LINE_BYTES    : bytes per cache-line-sized pmem transfer
//   BEATS         : pmem burst beats per line
//   BEAT_W        : bits per pmem beat
//   WORD_OFF_W    : width of the word-within-line offset (addr[4:2])
package dport_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WRITEBACK = 2'd2,
    RESP      = 2'd3
  } dport_state_t;

  localparam int LINE_BYTES = 32;
  localparam int BEATS      = 4;
  localparam int BEAT_W     = 64;
  localparam int WORD_OFF_W = 3;

endpackage

// File: rtl/dport_responder_if.sv
// dport_responder_if: word-level MEM-stage request/response bus.
//   mem_read/mem_write : level requests, held until mem_resp
//   mem_byte_enable    : byte lanes of the addressed word
//   mem_address        : byte address (bits [1:0] ignored by the responder)
//   mem_wdata          : lane-aligned store data
//   mem_resp           : one-cycle completion pulse
//   mem_rdata          : aligned word, valid while mem_resp=1
// Modports: master = MEM-stage requester, slave = responder.
interface dport_responder_if;

  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/dport_responder_line_merge.sv
// line_merge: combinational store merge into a full line.
//   line_in  : current line contents
//   word_off : word index within the line (addr[4:2] for a 256-bit line)
//   byte_en  : byte lanes of the addressed word to overwrite
//   wdata    : lane-aligned store data
//   line_out : line with the enabled bytes of the addressed word replaced
module line_merge
  import dport_types::*;
#(
  parameter int LINE_W = 256,
  parameter int OFF_W  = $clog2(LINE_W / 32)
) (
  input  logic [LINE_W-1:0] line_in,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [3:0]        byte_en,
  input  logic [31:0]       wdata,
  output logic [LINE_W-1:0] line_out
);

  always_comb begin
    line_out = line_in;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        line_out[(int'(word_off) * 4 + i) * 8 +: 8] = wdata[i * 8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dport_responder.sv
// dport_responder: MEM-stage data-port responder. Completes word-level
// loads/stores against a line-granular burst physical memory. Loads fetch
// the containing line and return the addressed word; stores fetch, merge
// and write back the whole line.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   mem          : word request/response bus (dport_responder_if.slave)
//   pmem_address : line-aligned burst address
//   pmem_read    : burst read in progress
//   pmem_write   : burst write in progress
//   pmem_wdata   : current write beat
//   pmem_rdata   : current read beat
//   pmem_resp    : one beat transferred this cycle
// Build option: DPORT_LINE_BUFFER_EN keeps the line register as a one-line
// buffer (valid + tag); read hits complete without pmem traffic and write
// hits skip the fetch.
module dport_responder
  import dport_types::*;
#(
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  dport_responder_if.slave  mem,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int KW     = $clog2(NBEATS);
  localparam int LB     = $clog2(LINE_W / 8);
  localparam int OFF_W  = $clog2(LINE_W / 32);

  dport_state_t      state_q, state_d;
  logic [KW-1:0]     k_q;
  logic [31:2]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_fill;
  logic [LINE_W-1:0] merge_in;
  logic [LINE_W-1:0] merged;
  logic [OFF_W-1:0]  merge_off;
  logic [3:0]        merge_be;
  logic [31:0]       merge_wdata;
  logic              req;
  logic              last_beat;
  logic              hit;

  wire unused_addr_bits = ^mem.mem_address[1:0];

  assign req       = mem.mem_read | mem.mem_write;
  assign last_beat = pmem_resp && (k_q == KW'(NBEATS - 1));

`ifdef DPORT_LINE_BUFFER_EN
  logic              buf_vld_q;
  logic [31:LB]      buf_tag_q;
  assign hit = buf_vld_q && (buf_tag_q == mem.mem_address[31:LB]);
`else
  assign hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; simultaneous read+write is handled as a write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem.mem_write) begin
          if (mem.mem_byte_enable == 4'h0) state_d = RESP;
          else if (hit)                    state_d = WRITEBACK;
          else                             state_d = FETCH;
        end else if (mem.mem_read) begin
          state_d = hit ? RESP : FETCH;
        end
      end
      FETCH:     if (last_beat) state_d = wr_q ? WRITEBACK : RESP;
      WRITEBACK: if (last_beat) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Line with the incoming beat already inserted, so the final fetch beat
  // and the store merge land in the same edge.
  always_comb begin
    line_fill = line_q;
    line_fill[int'(k_q) * BEAT_W +: BEAT_W] = pmem_rdata;
  end

  // In IDLE the merge sees the live request (write-hit path); otherwise it
  // sees the registered request and the filling line.
  always_comb begin
    if (state_q == IDLE) begin
      merge_in    = line_q;
      merge_off   = mem.mem_address[OFF_W+1:2];
      merge_be    = mem.mem_byte_enable;
      merge_wdata = mem.mem_wdata;
    end else begin
      merge_in    = line_fill;
      merge_off   = addr_q[OFF_W+1:2];
      merge_be    = be_q;
      merge_wdata = wdata_q;
    end
  end

  line_merge #(.LINE_W(LINE_W), .OFF_W(OFF_W)) u_line_merge (
    .line_in  (merge_in),
    .word_off (merge_off),
    .byte_en  (merge_be),
    .wdata    (merge_wdata),
    .line_out (merged)
  );

  // Request capture, line fill and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      line_q  <= '0;
`ifdef DPORT_LINE_BUFFER_EN
      buf_vld_q <= 1'b0;
      buf_tag_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= mem.mem_address[31:2];
            be_q    <= mem.mem_byte_enable;
            wdata_q <= mem.mem_wdata;
            wr_q    <= mem.mem_write;
`ifdef DPORT_LINE_BUFFER_EN
            if (mem.mem_write && (mem.mem_byte_enable != 4'h0) && hit)
              line_q <= merged;
`endif
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            k_q    <= k_q + KW'(1);
            line_q <= (last_beat && wr_q) ? merged : line_fill;
`ifdef DPORT_LINE_BUFFER_EN
            if (last_beat) begin
              buf_vld_q <= 1'b1;
              buf_tag_q <= addr_q[31:LB];
            end
`endif
          end
        end
        WRITEBACK: if (pmem_resp) k_q <= k_q + KW'(1);
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only
  always_comb begin
    mem.mem_resp  = (state_q == RESP);
    mem.mem_rdata = '0;
    pmem_read     = (state_q == FETCH);
    pmem_write    = (state_q == WRITEBACK);
    pmem_wdata    = '0;
    pmem_address  = {addr_q[31:LB], {LB{1'b0}}};
    if (state_q == RESP)
      mem.mem_rdata = line_q[int'(addr_q[OFF_W+1:2]) * 32 +: 32];
    if (state_q == WRITEBACK)
      pmem_wdata = line_q[int'(k_q) * BEAT_W +: BEAT_W];
  end

endmodule

// File: tb/tb_dport_responder.sv
// tb_dport_responder: directed scoreboard bench for dport_responder.
// A behavioural burst memory serves pmem with a per-beat wait table; the
// driver pushes the expected completion (cycle, word, memory line) and a
// separate monitor pops and compares on every mem_resp.
module tb_dport_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  always #5 clk = ~clk;

  dport_responder_if mem_if();

  dport_responder #(.BEAT_W(64), .LINE_W(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mem_if),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Burst memory model: index = address[7:5]; lines 0x80, 0xA0, 0xC0 preset
  logic [255:0] pm_mem [0:7] = '{
    256'h0, 256'h0, 256'h0, 256'h0,
    {64'h4444444444444444, 64'h3333333333333333,
     64'h2222222222222222, 64'h1111111111111111},
    {64'h1F1E1D1C1B1A1918, 64'h1716151413121110,
     64'h0F0E0D0C0B0A0908, 64'h0706050403020100},
    {4{64'h5555555555555555}},
    256'h0
  };
  int pm_beat;
  int pm_stall;
  int wait_tab [4] = '{0, 0, 0, 0};
  int pm_cycles = 0;
  logic both_seen = 1'b0;
  wire pm_active = pmem_read | pmem_write;

  assign pmem_resp  = pm_active && (pm_stall == 0);
  assign pmem_rdata = pm_mem[pmem_address[7:5]][pm_beat * 64 +: 64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_beat  <= 0;
      pm_stall <= wait_tab[0];
    end else if (!pm_active) begin
      pm_beat  <= 0;
      pm_stall <= wait_tab[0];
    end else if (pm_stall > 0) begin
      pm_stall <= pm_stall - 1;
    end else begin
      if (pmem_write) pm_mem[pmem_address[7:5]][pm_beat * 64 +: 64] <= pmem_wdata;
      pm_beat  <= (pm_beat + 1) % 4;
      pm_stall <= wait_tab[(pm_beat + 1) % 4];
    end
  end

  always @(posedge clk) begin
    if (pm_active) pm_cycles <= pm_cycles + 1;
    if (pmem_read && pmem_write) both_seen <= 1'b1;
  end

  typedef struct {
    string        name;
    int           exp_cyc;
    logic         chkd;
    logic [31:0]  exp_rd;
    logic         chkl;
    logic [2:0]   idx;
    logic [255:0] exp_line;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

`ifdef DPORT_LINE_BUFFER_EN
  logic        tb_valid = 1'b0;
  logic [26:0] tb_tag = '0;
`endif

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion latency in cycles after the sampling cycle
  function automatic int exp_lat(input logic wr, input logic [3:0] be, input logic [31:0] a);
    int w;
    w = wait_tab[0] + wait_tab[1] + wait_tab[2] + wait_tab[3];
    if (wr && be == 4'h0) return 1;
`ifdef DPORT_LINE_BUFFER_EN
    if (tb_valid && tb_tag == a[31:5]) return wr ? 5 : 1;
`else
    if (a[0] & ~a[0]) return 0;
`endif
    return (wr ? 9 : 5) + w;
  endfunction

  task automatic buf_update(input logic wr, input logic [3:0] be, input logic [31:0] a);
`ifdef DPORT_LINE_BUFFER_EN
    if (!(wr && be == 4'h0)) begin
      tb_valid = 1'b1;
      tb_tag   = a[31:5];
    end
`else
    if (wr && be == 4'h0 && a[0] && !a[0]) $display("unreachable");
`endif
  endtask

  task automatic push_wait(input string name, input int lat, input logic chkd,
                           input logic [31:0] exp_rd, input logic chkl,
                           input logic [2:0] idx, input logic [255:0] exp_line);
    exp_t e;
    logic seen;
    e.name = name; e.exp_cyc = cyc + lat; e.chkd = chkd; e.exp_rd = exp_rd;
    e.chkl = chkl; e.idx = idx; e.exp_line = exp_line;
    sb.push_back(e);
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (mem_if.mem_resp) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s/timeout: got no mem_resp expected one within 200 cycles", name);
      sb.delete();
    end
    mem_if.mem_read  = 1'b0;
    mem_if.mem_write = 1'b0;
  endtask

  task automatic req(input string name, input logic rd, input logic wr, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] wd, input logic chkd,
                     input logic [31:0] exp_rd, input logic chkl, input logic [255:0] exp_line);
    int lat;
    @(negedge clk);
    mem_if.mem_read        = rd;
    mem_if.mem_write       = wr;
    mem_if.mem_byte_enable = be;
    mem_if.mem_address     = a;
    mem_if.mem_wdata       = wd;
    lat = exp_lat(wr, be, a);
    buf_update(wr, be, a);
    push_wait(name, lat, chkd, exp_rd, chkl, a[7:5], exp_line);
  endtask

  // Monitor: pop and compare on every completion
  always @(negedge clk) begin
    if (rst_n && mem_if.mem_resp) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got mem_resp at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "/cycle"}, 256'(cyc), 256'(mon_e.exp_cyc));
        if (mon_e.chkd) check({mon_e.name, "/rdata"}, 256'(mem_if.mem_rdata), 256'(mon_e.exp_rd));
        check({mon_e.name, "/pmem_idle"}, 256'({pmem_read, pmem_write}), 256'(0));
        if (mon_e.chkl) check({mon_e.name, "/line"}, pm_mem[mon_e.idx], mon_e.exp_line);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run expected $finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   pc0;
    int   lat;
    mem_if.mem_read        = 1'b0;
    mem_if.mem_write       = 1'b0;
    mem_if.mem_byte_enable = 4'h0;
    mem_if.mem_address     = 32'h0;
    mem_if.mem_wdata       = 32'h0;

    repeat (2) @(negedge clk);
    check("rst/mem_resp",     256'(mem_if.mem_resp),  256'(0));
    check("rst/mem_rdata",    256'(mem_if.mem_rdata), 256'(0));
    check("rst/pmem_read",    256'(pmem_read),        256'(0));
    check("rst/pmem_write",   256'(pmem_write),       256'(0));
    check("rst/pmem_address", 256'(pmem_address),     256'(0));
    check("rst/pmem_wdata",   256'(pmem_wdata),       256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    req("rd_94", 1, 0, 4'hF, 32'h94, 32'h0, 1, 32'h33333333, 0, '0);
    req("rd_80", 1, 0, 4'hF, 32'h80, 32'h0, 1, 32'h11111111, 0, '0);
    req("rd_9c", 1, 0, 4'hF, 32'h9C, 32'h0, 1, 32'h44444444, 0, '0);
    req("rd_a8", 1, 0, 4'hF, 32'hA8, 32'h0, 1, 32'h0B0A0908, 0, '0);
    req("rd_b4", 1, 0, 4'hF, 32'hB4, 32'h0, 1, 32'h17161514, 0, '0);
    req("sb_81", 0, 1, 4'b0010, 32'h81, 32'h0000AB00, 1, 32'h1111AB11, 1,
        {64'h4444444444444444, 64'h3333333333333333,
         64'h2222222222222222, 64'h111111111111AB11});
    req("rd_80_after_sb", 1, 0, 4'hF, 32'h80, 32'h0, 1, 32'h1111AB11, 0, '0);
    req("sh_a6", 0, 1, 4'b1100, 32'hA6, 32'hBEEF0000, 1, 32'hBEEF0504, 1,
        {64'h1F1E1D1C1B1A1918, 64'h1716151413121110,
         64'h0F0E0D0C0B0A0908, 64'hBEEF050403020100});
    req("sw_bc", 0, 1, 4'hF, 32'hBC, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1,
        {64'hDEADBEEF1B1A1918, 64'h1716151413121110,
         64'h0F0E0D0C0B0A0908, 64'hBEEF050403020100});

    pc0 = pm_cycles;
    req("wr_be0", 0, 1, 4'h0, 32'h90, 32'hFFFFFFFF, 0, 32'h0, 0, '0);
    check("wr_be0/pmem_cycles", 256'(pm_cycles), 256'(pc0));

    req("rdwr_c0", 1, 1, 4'b0001, 32'hC0, 32'h000000EE, 1, 32'h555555EE, 1,
        {{3{64'h5555555555555555}}, 64'h55555555555555EE});

    // One wait before the first beat, two between beats: 7 wait cycles
    wait_tab = '{1, 2, 2, 2};
    req("rd_94_waits", 1, 0, 4'hF, 32'h94, 32'h0, 1, 32'h33333333, 0, '0);
    wait_tab = '{0, 0, 0, 0};

    req("rd_94_again", 1, 0, 4'hF, 32'h94, 32'h0, 1, 32'h33333333, 0, '0);

    // Reset pulse during writeback beat 2; the held store must rerun fully
    @(negedge clk);
    mem_if.mem_read        = 1'b0;
    mem_if.mem_write       = 1'b1;
    mem_if.mem_byte_enable = 4'b0001;
    mem_if.mem_address     = 32'hA0;
    mem_if.mem_wdata       = 32'h000000CC;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (pmem_write && pm_beat == 2) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid/reached_wb_beat2", 256'(seen), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid/pmem_write",   256'(pmem_write),      256'(0));
    check("rst_mid/pmem_read",    256'(pmem_read),       256'(0));
    check("rst_mid/mem_resp",     256'(mem_if.mem_resp), 256'(0));
    check("rst_mid/pmem_address", 256'(pmem_address),    256'(0));
    check("rst_mid/pmem_wdata",   256'(pmem_wdata),      256'(0));
`ifdef DPORT_LINE_BUFFER_EN
    tb_valid = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    lat = exp_lat(1'b1, 4'b0001, 32'hA0);
    buf_update(1'b1, 4'b0001, 32'hA0);
    push_wait("rst_mid/retry", lat, 1, 32'h030201CC, 1,
              3'd5, {64'hDEADBEEF1B1A1918, 64'h1716151413121110,
                     64'h0F0E0D0C0B0A0908, 64'hBEEF0504030201CC});

    repeat (3) @(negedge clk);
    check("end/scoreboard_empty", 256'(sb.size()), 256'(0));
    check("end/pmem_rd_wr_exclusive", 256'(both_seen), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
